// File: rtl/dmem_flat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_flat                                                       |
// | Purpose  : Single-port, byte-addressed data memory for the core's          |
// |            load/store port. One request per cycle, one-cycle registered    |
// |            response held until the requester acknowledges it (yumi).       |
// |            Ports are flat packed vectors so no shared struct types are     |
// |            needed between core and memory.                                 |
// |                                                                            |
// | Ports    : clk          in   1   clock, rising edge                        |
// |            reset        in   1   synchronous, active-low                   |
// |            port_flat_i  in  36   {valid, wen, byte_not_word, yumi,         |
// |                                   write_data[31:0]}                        |
// |            addr         in  32   byte address of the request               |
// |            port_flat_o  out 33   {valid, read_data[31:0]}                  |
// |                                                                            |
// | Options  : DMEM_CLEAR_ON_RESET_EN - when defined, every reset cycle also   |
// |            writes zero to all words. When undefined the array has no       |
// |            reset and its contents survive reset.                           |
// |                                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module dmem_flat #(
   parameter int NUM_WORDS_P  = 1024,
   parameter int DATA_WIDTH_P = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH_P+3:0] port_flat_i,
   input  logic [31:0]             addr,
   output logic [DATA_WIDTH_P:0]   port_flat_o
);

   localparam int c_LANES = DATA_WIDTH_P / 8;
   localparam int c_IDX_W = (NUM_WORDS_P > 1) ? $clog2(NUM_WORDS_P) : 1;

   // ------------------------------------------------------------------
   // Request unpacking
   // ------------------------------------------------------------------
   logic                    w_req_valid;
   logic                    w_wen;
   logic                    w_byte;
   logic                    w_yumi;
   logic [DATA_WIDTH_P-1:0] w_wdata;

   assign w_req_valid = port_flat_i[DATA_WIDTH_P+3];
   assign w_wen       = port_flat_i[DATA_WIDTH_P+2];
   assign w_byte      = port_flat_i[DATA_WIDTH_P+1];
   assign w_yumi      = port_flat_i[DATA_WIDTH_P];
   assign w_wdata     = port_flat_i[DATA_WIDTH_P-1:0];

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH_P-1:0] r_mem [NUM_WORDS_P];
   logic                    r_valid;
   logic [DATA_WIDTH_P-1:0] r_rdata;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [c_IDX_W-1:0]      w_idx;
   logic                    w_in_range;
   logic [DATA_WIDTH_P-1:0] w_cur_word;

   // The full 30-bit word index is compared so that status addresses far
   // above the array (0xDEADDEAD etc.) never alias onto a real word.
   assign w_idx      = addr[2 +: c_IDX_W];
   assign w_in_range = ({2'b00, addr[31:2]} < 32'(NUM_WORDS_P));
   assign w_cur_word = r_mem[w_idx];

   // ------------------------------------------------------------------
   // Handshake: a new request is taken when nothing is pending, or when
   // the pending response is being acknowledged in the same cycle.
   // Reset (low) blocks acceptance so a same-cycle request is dropped.
   // ------------------------------------------------------------------
   logic w_accept;
   logic w_mem_we;

   assign w_accept = reset & w_req_valid & (~r_valid | w_yumi);
   assign w_mem_we = w_accept & w_wen & w_in_range;

   // ------------------------------------------------------------------
   // Write merge: for a word write every lane takes its own slice of
   // write_data; for a byte write only the addressed lane changes and it
   // always takes write_data[7:0].
   // ------------------------------------------------------------------
   logic [DATA_WIDTH_P-1:0] w_merged;
   logic [c_LANES-1:0]      w_lane_sel;

   for (genvar g = 0; g < c_LANES; g++) begin : g_lane
      assign w_lane_sel[g]        = (addr[1:0] == 2'(g));
      assign w_merged[8*g +: 8]   = (!w_byte)      ? w_wdata[8*g +: 8] :
                                    w_lane_sel[g]  ? w_wdata[7:0]      :
                                                     w_cur_word[8*g +: 8];
   end

   // ------------------------------------------------------------------
   // Byte-lane extraction for byte reads (little-endian, lane 0 = [7:0])
   // ------------------------------------------------------------------
   logic [7:0] w_lane_byte;

   always_comb begin
      w_lane_byte = w_cur_word[7:0];
      case (addr[1:0])
         2'd0:    w_lane_byte = w_cur_word[7:0];
         2'd1:    w_lane_byte = w_cur_word[15:8];
         2'd2:    w_lane_byte = w_cur_word[23:16];
         default: w_lane_byte = w_cur_word[31:24];
      endcase
   end

   // ------------------------------------------------------------------
   // Response data. Writes return the word as it will be stored, which is
   // exactly the merged value. Out-of-range accesses return zero but are
   // still acknowledged so the requester sees the access complete.
   // ------------------------------------------------------------------
   logic [DATA_WIDTH_P-1:0] w_resp_data;

   always_comb begin
      w_resp_data = '0;
      if (w_in_range) begin
         if (w_wen) begin
            w_resp_data = w_merged;
         end else if (w_byte) begin
            w_resp_data = {{(DATA_WIDTH_P-8){1'b0}}, w_lane_byte};
         end else begin
            w_resp_data = w_cur_word;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response register: updated only on accept, so data stays stable for
   // as long as the response is pending.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_rdata <= w_resp_data;
      end else if (w_yumi) begin
         r_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Storage array
   // ------------------------------------------------------------------
`ifdef DMEM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WORDS_P; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_we) begin
         r_mem[w_idx] <= w_merged;
      end
   end
`else
   // No reset on the array: contents survive reset and are preloaded
   // through the normal request port.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= w_merged;
      end
   end
`endif

   assign port_flat_o = {r_valid, r_rdata};

endmodule

`default_nettype wire

// File: tb/tb_dmem_flat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_flat                                                    |
// | Purpose  : Self-checking bench for dmem_flat: preload/readback, byte       |
// |            lanes, handshake hold/drop, out-of-range accesses, randomized   |
// |            traffic against a transaction-level reference, reset behaviour. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module tb_dmem_flat;

   localparam int NW = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_wen, req_byte, req_yumi;
   logic [31:0] req_wdata;
   logic [31:0] addr;
   logic [35:0] port_flat_i;
   logic [32:0] port_flat_o;
   logic        valid_o;
   logic [31:0] rdata_o;

   assign port_flat_i = {req_valid, req_wen, req_byte, req_yumi, req_wdata};
   assign valid_o     = port_flat_o[32];
   assign rdata_o     = port_flat_o[31:0];

   dmem_flat #(.NUM_WORDS_P(NW), .DATA_WIDTH_P(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .port_flat_i (port_flat_i),
      .addr        (addr),
      .port_flat_o (port_flat_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a plain word array plus the response the requester
   // should currently be seeing.
   logic [31:0] ref_mem [NW];
   bit          ref_pending = 1'b0;
   logic [31:0] ref_resp    = 32'h0;

   function automatic logic [31:0] ref_access(bit wen, bit bnw, logic [31:0] a, logic [31:0] wd);
      int unsigned word  = a >> 2;
      int unsigned shift = {27'b0, a[1:0], 3'b000};
      logic [9:0]  wi    = a[11:2];
      if (word >= NW) return 32'h0;
      if (wen) begin
         if (bnw) ref_mem[wi] = (ref_mem[wi] & ~(32'hFF << shift)) | ((wd & 32'hFF) << shift);
         else     ref_mem[wi] = wd;
         return ref_mem[wi];
      end
      if (bnw) return (ref_mem[wi] >> shift) & 32'hFF;
      return ref_mem[wi];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(bit v, bit w, bit b, bit y, logic [31:0] a, logic [31:0] d);
      req_valid = v; req_wen = w; req_byte = b; req_yumi = y;
      addr = a; req_wdata = d;
   endtask

   // Advance the reference by the rules of the port for the inputs that
   // are present at the coming edge, then cross the edge and settle.
   task automatic step();
      if (!reset) begin
         ref_pending = 1'b0;
         ref_resp    = 32'h0;
`ifdef DMEM_CLEAR_ON_RESET_EN
         for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
`endif
      end else if (req_valid && (!ref_pending || req_yumi)) begin
         ref_pending = 1'b1;
         ref_resp    = ref_access(req_wen, req_byte, addr, req_wdata);
      end else if (req_yumi) begin
         ref_pending = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_resp(string tag);
      chk({tag, "_valid"}, {31'b0, valid_o}, {31'b0, ref_pending});
      if (ref_pending) chk({tag, "_data"}, rdata_o, ref_resp);
   endtask

   task automatic readback_all(string tag);
      for (int k = 0; k < NW; k++) begin
         drive(1, 0, 0, 1, 32'(k) << 2, 32'h0);
         step();
         check_resp(tag);
      end
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      check_resp({tag, "_drain"});
   endtask

   logic [31:0] oor_addrs [6] = '{32'hDEADDEAD, 32'h600DBEEF, 32'hC0DEC0DE,
                                  32'hC0FFEEEE, 32'h0000_1000, 32'h0000_1003};

   initial begin
      logic [31:0] ra;
      reset = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0);

      // Reset state
      step();
      step();
      chk("reset_valid", {31'b0, valid_o}, 32'h0);
      chk("reset_data", rdata_o, 32'h0);
      reset = 1'b1;

      // Preload back-to-back with yumi held high
      for (int k = 0; k < NW; k++) begin
         drive(1, 1, 0, 1, 32'(k) << 2, 32'(k));
         step();
         check_resp("preload");
      end
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      check_resp("preload_drain");

      readback_all("readback");
      drive(1, 0, 0, 1, 32'h0000_0FFC, 32'h0);
      step();
      chk("last_word", rdata_o, 32'd1023);

      // Byte lanes
      drive(1, 1, 0, 1, 32'h10, 32'h11223344); step(); chk("bw_word_wr", rdata_o, 32'h11223344);
      drive(1, 1, 1, 1, 32'h12, 32'h000000AA); step(); chk("bw_byte_wr", rdata_o, 32'h11AA3344);
      drive(1, 0, 0, 1, 32'h10, 32'h0);        step(); chk("bw_word_rd", rdata_o, 32'h11AA3344);
      drive(1, 0, 1, 1, 32'h13, 32'h0);        step(); chk("bw_byte_rd3", rdata_o, 32'h00000011);
      drive(1, 0, 1, 1, 32'h12, 32'h0);        step(); chk("bw_byte_rd2", rdata_o, 32'h000000AA);
      drive(1, 0, 1, 1, 32'h10, 32'h0);        step(); chk("bw_byte_rd0", rdata_o, 32'h00000044);
      drive(0, 0, 0, 1, 32'h0, 32'h0);         step(); check_resp("bw_drain");

      // Handshake: response held, second request dropped while pending
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      step();
      chk("hs_first_valid", {31'b0, valid_o}, 32'h1);
      chk("hs_first_data", rdata_o, 32'h0);
      drive(1, 0, 0, 0, 32'h8, 32'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hs_hold_valid", {31'b0, valid_o}, 32'h1);
         chk("hs_hold_data", rdata_o, 32'h0);
      end
      drive(1, 0, 0, 1, 32'h8, 32'h0);
      step();
      chk("hs_second_data", rdata_o, 32'h2);
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      chk("hs_release", {31'b0, valid_o}, 32'h0);
      step();
      chk("hs_idle_yumi", {31'b0, valid_o}, 32'h0);

      // Out of range: acknowledged, zero data, nothing stored
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 1, oor_addrs[i], 32'h5);
         step();
         chk("oor_valid", {31'b0, valid_o}, 32'h1);
         chk("oor_data", rdata_o, 32'h0);
      end
      drive(1, 0, 0, 1, 32'hDEADDEAD, 32'h0);
      step();
      chk("oor_read", rdata_o, 32'h0);
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      check_resp("oor_drain");
      readback_all("oor_unchanged");

      // Randomized traffic with random valid/yumi
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            ra = oor_addrs[$urandom_range(0, 5)];
         else
            ra = {20'b0, 10'($urandom_range(0, NW - 1)), 2'($urandom_range(0, 3))};
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ra, $urandom);
         step();
         check_resp("rand");
      end
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      check_resp("rand_drain");
      readback_all("rand_readback");

      // Reset in the middle of a pending response
      drive(1, 1, 0, 1, 32'h10, 32'h4);
      step();
      chk("rst_prep", rdata_o, 32'h4);
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      step();
      drive(1, 0, 0, 0, 32'h4, 32'h0);
      step();
      chk("rst_pending", {31'b0, valid_o}, 32'h1);
      reset = 1'b0;
      drive(1, 1, 0, 1, 32'h10, 32'h99);
      step();
      chk("rst_drop_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_drop_data", rdata_o, 32'h0);
      reset = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      step();
      check_resp("rst_idle");
      drive(1, 0, 0, 1, 32'h10, 32'h0);
      step();
`ifdef DMEM_CLEAR_ON_RESET_EN
      chk("rst_mem4", rdata_o, 32'h0);
`else
      chk("rst_mem4", rdata_o, 32'h4);
`endif
      drive(1, 0, 0, 1, 32'hFFC, 32'h0);
      step();
      check_resp("rst_last");
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      step();
      check_resp("rst_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
